// File: rtl/det_bareiss_nxn.sv
// rtl/det_bareiss_nxn.sv - runtime-sized signed determinant engine (fraction-free Bareiss elimination)
//
// Reads an N x N signed matrix row-major through an i/j read port, eliminates in place with
// row pivoting through a permutation table, and writes the determinant once.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, size     1-cycle start pulse (ignored while busy) and matrix order N
//   i, j, read      element read request; read_data returns M[i][j] one cycle later
//   write           1-cycle strobe with write_data = determinant
//   finish, busy    run complete / run in progress
//   ovf, err        sticky per run: quotient overflowed RW / size out of range
module det_bareiss_nxn #(
  parameter int DW    = 20,
  parameter int MAX_N = 8,
  parameter int RW    = 64,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW:0]   size,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic          read,
  input  logic [DW-1:0] read_data,
  output logic          write,
  output logic [RW-1:0] write_data,
  output logic          finish,
  output logic          busy,
  output logic          ovf,
  output logic          err
);

  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int CW = $clog2(2 * RW + 1);
  localparam logic [IW:0] MAX_NV = (IW + 1)'(MAX_N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PIVOT, S_SCAN, S_ELIM, S_DIV, S_RESULT, S_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [IW:0]     n_q, n_d;
  logic [AW-1:0]   k_q, k_d, r_q, r_d, c_q, c_d;
  logic [RW-1:0]   prev_q, prev_d;
  logic            sign_q, sign_d, zero_q, zero_d;
  logic [AW-1:0]   perm_q [MAX_N];
  logic [AW-1:0]   perm_d [MAX_N];
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            read_q, read_d, write_q, write_d;
  logic [RW-1:0]   write_data_q, write_data_d;
  logic            finish_q, finish_d, busy_q, busy_d, ovf_q, ovf_d, err_q, err_d;
  logic            rd_v_q, rd_v_d;
  logic [AW-1:0]   rd_i_q, rd_i_d, rd_j_q, rd_j_d;
  logic [RW-1:0]   dv_rem_q, dv_rem_d, dv_den_q, dv_den_d;
  logic [2*RW-1:0] dv_quo_q, dv_quo_d;
  logic [CW-1:0]   dv_cnt_q, dv_cnt_d;
  logic            dv_neg_q, dv_neg_d;

  // Matrix storage, physical rows; logical row x lives at perm[x].
  logic [RW-1:0]   m_q [MAX_N][MAX_N];
  logic            mem_we;
  logic [AW-1:0]   mem_r, mem_c;
  logic [RW-1:0]   mem_wd;

  function automatic logic [2*RW-1:0] sext(input logic [RW-1:0] x);
    return {{RW{x[RW-1]}}, x};
  endfunction

  logic [IW-1:0]   nm1_iw;
  logic [AW-1:0]   nm1_a, pk, pr;
  logic [RW-1:0]   p_kk, p_rc, p_rk, p_kc, det_val, load_ext;
  logic [2*RW-1:0] num, quo_nx, q_signed;
  logic [RW:0]     rem_sh, diff;
  logic [RW-1:0]   rem_nx;
  logic            ge, num_fits, q_fits, elem_done;

  always_comb begin
    nm1_iw   = n_q[IW-1:0] - 1'b1;
    nm1_a    = nm1_iw[AW-1:0];
    pk       = perm_q[k_q];
    pr       = perm_q[r_q];
    p_kk     = m_q[pk][k_q];
    p_rc     = m_q[pr][c_q];
    p_rk     = m_q[pr][k_q];
    p_kc     = m_q[pk][c_q];
    // Low 2*RW bits of the product are the same for signed and unsigned operands.
    num      = sext(p_kk) * sext(p_rc) - sext(p_rk) * sext(p_kc);
    num_fits = (&num[2*RW-1:RW-1]) | ~(|num[2*RW-1:RW-1]);
    det_val  = m_q[perm_q[nm1_a]][nm1_a];
    load_ext = {{(RW - DW){read_data[DW-1]}}, read_data};
    // Restoring division step on magnitudes; diff[RW] is the borrow.
    rem_sh   = {dv_rem_q, dv_quo_q[2*RW-1]};
    diff     = rem_sh - {1'b0, dv_den_q};
    ge       = ~diff[RW];
    rem_nx   = ge ? diff[RW-1:0] : rem_sh[RW-1:0];
    quo_nx   = {dv_quo_q[2*RW-2:0], ge};
    q_signed = dv_neg_q ? -quo_nx : quo_nx;
    q_fits   = (&q_signed[2*RW-1:RW-1]) | ~(|q_signed[2*RW-1:RW-1]);
  end

  always_comb begin
    state_d = state_q;  n_d = n_q;  k_d = k_q;  r_d = r_q;  c_d = c_q;
    prev_d = prev_q;  sign_d = sign_q;  zero_d = zero_q;  perm_d = perm_q;
    i_d = i_q;  j_d = j_q;  read_d = read_q;  write_d = 1'b0;
    write_data_d = write_data_q;  finish_d = finish_q;  busy_d = busy_q;
    ovf_d = ovf_q;  err_d = err_q;
    rd_v_d = 1'b0;  rd_i_d = rd_i_q;  rd_j_d = rd_j_q;
    dv_rem_d = dv_rem_q;  dv_quo_d = dv_quo_q;  dv_cnt_d = dv_cnt_q;
    dv_neg_d = dv_neg_q;  dv_den_d = dv_den_q;
    mem_we = rd_v_q;  mem_r = rd_i_q;  mem_c = rd_j_q;  mem_wd = load_ext;
    elem_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d = size;  k_d = '0;  prev_d = RW'(1);  sign_d = 1'b0;  zero_d = 1'b0;
          for (int x = 0; x < MAX_N; x++) perm_d[x] = AW'(x);
          busy_d = 1'b1;  finish_d = 1'b0;  ovf_d = 1'b0;  err_d = 1'b0;
          write_data_d = '0;
          if (size == '0 || size > MAX_NV) begin
            err_d = 1'b1;  zero_d = 1'b1;  state_d = S_RESULT;
          end else begin
            read_d = 1'b1;  i_d = '0;  j_d = '0;  state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        rd_v_d = read_q;  rd_i_d = i_q[AW-1:0];  rd_j_d = j_q[AW-1:0];
        if (read_q) begin
          if (j_q == nm1_iw && i_q == nm1_iw) begin
            read_d = 1'b0;
          end else if (j_q == nm1_iw) begin
            j_d = '0;  i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          // Last element is being stored this cycle.
          state_d = (n_q == (IW + 1)'(1)) ? S_RESULT : S_PIVOT;
        end
      end
      S_PIVOT: begin
        r_d = k_q + 1'b1;
        c_d = k_q + 1'b1;
        state_d = (p_kk != '0) ? S_ELIM : S_SCAN;
      end
      S_SCAN: begin
        if (p_rk != '0) begin
          perm_d[k_q] = perm_q[r_q];
          perm_d[r_q] = perm_q[k_q];
          sign_d = ~sign_q;
          r_d = k_q + 1'b1;
          c_d = k_q + 1'b1;
          state_d = S_ELIM;
        end else if (r_q == nm1_a) begin
          zero_d = 1'b1;
          state_d = S_RESULT;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      S_ELIM: begin
        if (k_q == '0) begin
          // prev is 1 on the first step: the numerator is the quotient.
          mem_we = 1'b1;  mem_r = pr;  mem_c = c_q;  mem_wd = num[RW-1:0];
          if (!num_fits) ovf_d = 1'b1;
          elem_done = 1'b1;
        end else begin
          dv_quo_d = num[2*RW-1] ? -num : num;
          dv_den_d = prev_q[RW-1] ? -prev_q : prev_q;
          dv_neg_d = num[2*RW-1] ^ prev_q[RW-1];
          dv_rem_d = '0;
          dv_cnt_d = CW'(2 * RW);
          state_d  = S_DIV;
        end
      end
      S_DIV: begin
        dv_rem_d = rem_nx;
        dv_quo_d = quo_nx;
        dv_cnt_d = dv_cnt_q - 1'b1;
        if (dv_cnt_q == CW'(1)) begin
          mem_we = 1'b1;  mem_r = pr;  mem_c = c_q;  mem_wd = q_signed[RW-1:0];
          if (!q_fits) ovf_d = 1'b1;
          elem_done = 1'b1;
        end
      end
      S_RESULT: begin
        write_d  = 1'b1;
        finish_d = 1'b1;
        write_data_d = zero_q ? '0 : (sign_q ? -det_val : det_val);
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (elem_done) begin
      if (c_q == nm1_a) begin
        if (r_q == nm1_a) begin
          prev_d  = p_kk;
          k_d     = k_q + 1'b1;
          state_d = (k_q + 1'b1 == nm1_a) ? S_RESULT : S_PIVOT;
        end else begin
          r_d = r_q + 1'b1;  c_d = k_q + 1'b1;  state_d = S_ELIM;
        end
      end else begin
        c_d = c_q + 1'b1;  state_d = S_ELIM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  n_q <= '0;  k_q <= '0;  r_q <= '0;  c_q <= '0;
      prev_q <= '0;  sign_q <= 1'b0;  zero_q <= 1'b0;
      for (int x = 0; x < MAX_N; x++) perm_q[x] <= AW'(x);
      i_q <= '0;  j_q <= '0;  read_q <= 1'b0;  write_q <= 1'b0;  write_data_q <= '0;
      finish_q <= 1'b0;  busy_q <= 1'b0;  ovf_q <= 1'b0;  err_q <= 1'b0;
      rd_v_q <= 1'b0;  rd_i_q <= '0;  rd_j_q <= '0;
      dv_rem_q <= '0;  dv_quo_q <= '0;  dv_cnt_q <= '0;  dv_neg_q <= 1'b0;  dv_den_q <= '0;
    end else begin
      state_q <= state_d;  n_q <= n_d;  k_q <= k_d;  r_q <= r_d;  c_q <= c_d;
      prev_q <= prev_d;  sign_q <= sign_d;  zero_q <= zero_d;  perm_q <= perm_d;
      i_q <= i_d;  j_q <= j_d;  read_q <= read_d;  write_q <= write_d;
      write_data_q <= write_data_d;
      finish_q <= finish_d;  busy_q <= busy_d;  ovf_q <= ovf_d;  err_q <= err_d;
      rd_v_q <= rd_v_d;  rd_i_q <= rd_i_d;  rd_j_q <= rd_j_d;
      dv_rem_q <= dv_rem_d;  dv_quo_q <= dv_quo_d;  dv_cnt_q <= dv_cnt_d;
      dv_neg_q <= dv_neg_d;  dv_den_q <= dv_den_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) m_q[mem_r][mem_c] <= mem_wd;
  end

  assign i          = i_q;
  assign j          = j_q;
  assign read       = read_q;
  assign write      = write_q;
  assign write_data = write_data_q;
  assign finish     = finish_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_det_bareiss_nxn.sv
// tb/tb_det_bareiss_nxn.sv - directed self-checking bench for det_bareiss_nxn
module tb_det_bareiss_nxn;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  size;
  logic [3:0]  i, j;
  logic        read;
  logic [19:0] read_data;
  logic        write;
  logic [63:0] write_data;
  logic        finish, busy, ovf, err;

  det_bareiss_nxn dut (
    .clk(clk), .reset(reset), .start(start), .size(size),
    .i(i), .j(j), .read(read), .read_data(read_data),
    .write(write), .write_data(write_data), .finish(finish),
    .busy(busy), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  logic [19:0] mem [16][16];
  always @(posedge clk) if (read) read_data <= mem[i][j];

  int n_checks = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [7:0] rd_log [1024];

  always @(negedge clk) begin
    if (read) begin
      rd_log[rd_cnt % 1024] <= {i, j};
      rd_cnt <= rd_cnt + 1;
    end
    if (write) wr_cnt <= wr_cnt + 1;
  end

  task automatic clear_mem();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) mem[a][b] = '0;
  endtask

  task automatic start_run(input logic [4:0] n);
    @(posedge clk); #1;
    size = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      if (finish === 1'b1) seen = 1;
      cyc++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: finish=%b after %0d cycles, expected 1", tag, finish, cyc);
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] exp, input int base_w);
    n_checks++;
    if (write !== 1'b1 || write_data !== exp) begin
      n_fail++;
      $display("FAIL %s_det: write=%b write_data=%0d expected write=1 write_data=%0d",
               tag, write, $signed(write_data), $signed(exp));
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || finish !== 1'b1 || write !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b finish=%b write=%b expected 0 1 0", tag, busy, finish, write);
    end
    n_checks++;
    if (wr_cnt - base_w !== 1) begin
      n_fail++;
      $display("FAIL %s_wrcount: got %0d writes expected 1", tag, wr_cnt - base_w);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({read, write, finish, busy, ovf, err} !== 6'b0 || i !== 4'd0 || j !== 4'd0 || write_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b wr=%b fin=%b busy=%b ovf=%b err=%b i=%0d j=%0d wd=%0d expected all 0",
               read, write, finish, busy, ovf, err, i, j, write_data);
    end
  endtask

  task automatic test_n1();
    int bw = wr_cnt;
    clear_mem();
    mem[0][0] = -20'sd7;
    start_run(5'd1);
    wait_done("n1");
    check_result("n1", -64'sd7, bw);
    n_checks++;
    if (ovf !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_flags: ovf=%b err=%b expected 0 0", ovf, err);
    end
  endtask

  task automatic test_n3();
    int bw = wr_cnt;
    int br = rd_cnt;
    logic [7:0] exp_a;
    clear_mem();
    mem[0][0] = 20'sd2; mem[0][1] = -20'sd3; mem[0][2] = 20'sd1;
    mem[1][0] = 20'sd2; mem[1][1] = 20'sd0;  mem[1][2] = -20'sd1;
    mem[2][0] = 20'sd1; mem[2][1] = 20'sd4;  mem[2][2] = 20'sd5;
    start_run(5'd3);
    // start while busy must be ignored
    repeat (3) @(posedge clk);
    #1 size = 5'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("n3");
    check_result("n3", 64'sd49, bw);
    n_checks++;
    if (rd_cnt - br !== 9) begin
      n_fail++;
      $display("FAIL n3_rdcount: got %0d reads expected 9", rd_cnt - br);
    end
    for (int t = 0; t < 9; t++) begin
      exp_a = {4'(t / 3), 4'(t % 3)};
      n_checks++;
      if (rd_log[(br + t) % 1024] !== exp_a) begin
        n_fail++;
        $display("FAIL n3_addr%0d: got i=%0d j=%0d expected i=%0d j=%0d", t,
                 rd_log[(br + t) % 1024][7:4], rd_log[(br + t) % 1024][3:0], exp_a[7:4], exp_a[3:0]);
      end
    end
  endtask

  task automatic test_swap();
    int bw = wr_cnt;
    clear_mem();
    mem[0][1] = 20'sd1;
    mem[1][0] = 20'sd1;
    start_run(5'd2);
    wait_done("swap");
    check_result("swap", -64'sd1, bw);
  endtask

  task automatic test_singular();
    int bw = wr_cnt;
    clear_mem();
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) mem[a][b] = 20'(3 * a + b + 1);
    start_run(5'd3);
    wait_done("sing");
    check_result("sing", 64'sd0, bw);
    n_checks++;
    if (ovf !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL sing_flags: ovf=%b err=%b expected 0 0", ovf, err);
    end
  endtask

  task automatic test_err(input logic [4:0] sz);
    int bw = wr_cnt;
    int br = rd_cnt;
    string tag;
    tag = $sformatf("err%0d", sz);
    start_run(sz);
    // the run is busy now; this start must not launch a read sequence
    size = 5'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(tag);
    check_result(tag, 64'd0, bw);
    n_checks++;
    if (err !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: err=%b ovf=%b expected 1 0", tag, err, ovf);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_cnt - br !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_noread: reads=%0d busy=%b expected 0 0", tag, rd_cnt - br, busy);
    end
  endtask

  task automatic load_diag8();
    clear_mem();
    for (int a = 0; a < 8; a++) mem[a][a] = 20'sd2;
  endtask

  task automatic test_diag8();
    int bw = wr_cnt;
    load_diag8();
    start_run(5'd8);
    wait_done("diag8");
    check_result("diag8", 64'sd256, bw);
    n_checks++;
    if (ovf !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL diag8_flags: ovf=%b err=%b expected 0 0", ovf, err);
    end
  endtask

  task automatic test_reset_mid_load();
    int bw;
    load_diag8();
    start_run(5'd8);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({read, write, finish, busy, ovf, err} !== 6'b0 || i !== 4'd0 || j !== 4'd0 || write_data !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_state: rd=%b wr=%b fin=%b busy=%b ovf=%b err=%b i=%0d j=%0d wd=%0d expected all 0",
               read, write, finish, busy, ovf, err, i, j, write_data);
    end
    bw = wr_cnt;
    start_run(5'd8);
    wait_done("midreset");
    check_result("midreset", 64'sd256, bw);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    size  = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    test_reset();
    #1 reset = 1'b0;
    test_n1();
    test_n3();
    test_swap();
    test_singular();
    test_err(5'd9);
    test_err(5'd0);
    test_diag8();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
